// File: rtl/snitch_tcdm_bank_arbiter.sv
// Per-bank TCDM scheduler: round-robin grant with lock-in and a starvation guard,
// fixed-latency response routing. Packed layouts: req = {q_valid, addr, write, amo[3:0], data, strb, user},
// rsp = {q_ready, p_valid, p_data}.
module snitch_tcdm_bank_arbiter #(
  parameter int unsigned NumInp     = 4,
  parameter int unsigned RspLatency = 1,
  parameter int unsigned MaxWait    = 8,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned UserWidth  = 1,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned ReqWidth  = 1 + AddrWidth + 1 + 4 + DataWidth + StrbWidth + UserWidth,
  localparam int unsigned RspWidth  = 2 + DataWidth,
  localparam int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumInp*ReqWidth-1:0]   inp_req_i,
  output logic [NumInp*RspWidth-1:0]   inp_rsp_o,
  output logic [ReqWidth-1:0]          oup_req_o,
  input  logic [RspWidth-1:0]          oup_rsp_i,
  output logic [IdxWidth-1:0]          idx_o
);

  localparam int unsigned WaitWidth = $clog2(MaxWait + 1);
  localparam int unsigned PadWidth  = 1 << IdxWidth;
  localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(MaxWait);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [3:0]           amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } req_chan_t;

  typedef struct packed {
    logic      q_valid;
    req_chan_t q;
  } tcdm_req_t;

  typedef struct packed {
    logic                 q_ready;
    logic                 p_valid;
    logic [DataWidth-1:0] p_data;
  } tcdm_rsp_t;

  tcdm_req_t            req [NumInp];
  tcdm_rsp_t            rsp [NumInp];
  tcdm_rsp_t            bank_rsp;
  tcdm_req_t            oup_req;
  logic [NumInp-1:0]    inp_valid;
  logic [PadWidth-1:0]  valid_pad;

  logic [IdxWidth-1:0]  rr_q, rr_d, lock_idx_q, lock_idx_d, gnt_idx, cand;
  logic                 lock_q, lock_d, starve_hit, rr_hit, hs;
  logic [WaitWidth-1:0] wait_q [NumInp];
  logic [WaitWidth-1:0] wait_d [NumInp];
  logic                 rsp_vld_q [RspLatency];
  logic                 rsp_vld_d [RspLatency];
  logic [IdxWidth-1:0]  rsp_idx_q [RspLatency];
  logic [IdxWidth-1:0]  rsp_idx_d [RspLatency];
  logic                 unused_bank_pvalid;

  assign bank_rsp           = oup_rsp_i;
  assign unused_bank_pvalid = bank_rsp.p_valid;
  assign valid_pad          = PadWidth'(inp_valid);

  for (genvar gi = 0; gi < NumInp; gi++) begin : g_inp
    assign req[gi]         = inp_req_i[gi*ReqWidth +: ReqWidth];
    assign inp_valid[gi]   = req[gi].q_valid;
    assign rsp[gi].q_ready = rst_ni & bank_rsp.q_ready & (gnt_idx == IdxWidth'(gi));
    assign rsp[gi].p_valid = rsp_vld_q[RspLatency-1] & (rsp_idx_q[RspLatency-1] == IdxWidth'(gi));
    assign rsp[gi].p_data  = bank_rsp.p_data;
    assign inp_rsp_o[gi*RspWidth +: RspWidth] = rsp[gi];
  end

  // Grant priority: lock, then lowest starved input, then round-robin from rr_q.
  always_comb begin
    gnt_idx    = '0;
    cand       = '0;
    starve_hit = 1'b0;
    rr_hit     = 1'b0;
    if (lock_q) begin
      gnt_idx = lock_idx_q;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        if (!starve_hit && inp_valid[i] && wait_q[i] == WaitMax) begin
          gnt_idx    = IdxWidth'(i);
          starve_hit = 1'b1;
        end
      end
      for (int k = 0; k < NumInp; k++) begin
        cand = IdxWidth'((32'(rr_q) + 32'(k)) % NumInp);
        if (!starve_hit && !rr_hit && valid_pad[cand]) begin
          gnt_idx = cand;
          rr_hit  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    oup_req = req[0];
    for (int i = 0; i < NumInp; i++) begin
      if (gnt_idx == IdxWidth'(i)) oup_req = req[i];
    end
    oup_req.q_valid = oup_req.q_valid & rst_ni;
  end

  assign oup_req_o = oup_req;
  assign idx_o     = gnt_idx;
  assign hs        = oup_req.q_valid & bank_rsp.q_ready;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (!lock_q) begin
      if (oup_req.q_valid && !bank_rsp.q_ready) begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
    end else if (hs) begin
      lock_d = 1'b0;
    end
    if (hs) rr_d = (gnt_idx == IdxWidth'(NumInp - 1)) ? '0 : IdxWidth'(gnt_idx + 1'b1);
    for (int i = 0; i < NumInp; i++) begin
      if (inp_valid[i] && !(hs && gnt_idx == IdxWidth'(i))) begin
        wait_d[i] = (wait_q[i] == WaitMax) ? WaitMax : wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = '0;
      end
    end
    rsp_vld_d[0] = hs;
    rsp_idx_d[0] = gnt_idx;
    for (int s = 1; s < RspLatency; s++) begin
      rsp_vld_d[s] = rsp_vld_q[s-1];
      rsp_idx_d[s] = rsp_idx_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < NumInp; i++) wait_q[i] <= '0;
      for (int s = 0; s < RspLatency; s++) begin
        rsp_vld_q[s] <= 1'b0;
        rsp_idx_q[s] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int i = 0; i < NumInp; i++) wait_q[i] <= wait_d[i];
      for (int s = 0; s < RspLatency; s++) begin
        rsp_vld_q[s] <= rsp_vld_d[s];
        rsp_idx_q[s] <= rsp_idx_d[s];
      end
    end
  end

  // A locked requester must keep its request up until the bank accepts it.
  lock_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> oup_req.q_valid);

endmodule

// File: tb/tb_snitch_tcdm_bank_arbiter.sv
// Directed table-driven bench for the TCDM bank arbiter: round-robin, lock-in,
// starvation, response latency, mid-flight reset and the single-input case.
module tb_snitch_tcdm_bank_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, UW = 1;
  localparam int ReqW = 1 + AW + 1 + 4 + DW + SW + UW;
  localparam int RspW = 2 + DW;

  typedef struct packed {
    logic q_valid; logic [AW-1:0] addr; logic write; logic [3:0] amo;
    logic [DW-1:0] data; logic [SW-1:0] strb; logic [UW-1:0] user;
  } req_t;
  typedef struct packed { logic q_ready; logic p_valid; logic [DW-1:0] p_data; } rsp_t;
  typedef struct {
    logic [3:0] valid; logic ready; logic [1:0] exp_idx; logic exp_ov;
    logic [3:0] exp_qr; logic [3:0] exp_pv;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  req_t req_a [4];
  req_t req_b [4];
  req_t c_req;
  rsp_t bank;
  logic [4*ReqW-1:0] a_req_flat, b_req_flat;
  logic [4*RspW-1:0] a_rsp, b_rsp;
  logic [RspW-1:0]   c_rsp;
  logic [ReqW-1:0]   a_oup, b_oup, c_oup;
  logic [1:0]        a_idx, b_idx;
  logic [0:0]        c_idx;

  assign a_req_flat = {req_a[3], req_a[2], req_a[1], req_a[0]};
  assign b_req_flat = {req_b[3], req_b[2], req_b[1], req_b[0]};

  snitch_tcdm_bank_arbiter #(.NumInp(4), .RspLatency(1), .MaxWait(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .inp_req_i(a_req_flat), .inp_rsp_o(a_rsp),
    .oup_req_o(a_oup), .oup_rsp_i(bank), .idx_o(a_idx));
  snitch_tcdm_bank_arbiter #(.NumInp(4), .RspLatency(3), .MaxWait(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .inp_req_i(b_req_flat), .inp_rsp_o(b_rsp),
    .oup_req_o(b_oup), .oup_rsp_i(bank), .idx_o(b_idx));
  snitch_tcdm_bank_arbiter #(.NumInp(1), .RspLatency(2), .MaxWait(8)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .inp_req_i(c_req), .inp_rsp_o(c_rsp),
    .oup_req_o(c_oup), .oup_rsp_i(bank), .idx_o(c_idx));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [1:0] g,
                              input logic ov, input logic [3:0] qr, input logic [3:0] pv);
    vec_t t;
    t.valid = v; t.ready = r; t.exp_idx = g; t.exp_ov = ov; t.exp_qr = qr; t.exp_pv = pv;
    return t;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      req_a[i].q_valid = 1'b0;
      req_b[i].q_valid = 1'b0;
    end
    c_req.q_valid = 1'b0;
    bank.q_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    #1;
    clear_inputs();
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int inst, input vec_t v, input int n);
    logic [4*RspW-1:0] flat;
    req_t o;
    rsp_t r;
    logic [1:0] id;
    logic [3:0] qr, pv;
    logic [DW-1:0] pd [4];
    string p;
    p = $sformatf("%s%0d", (inst == 0) ? "A" : "B", n);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (inst == 0) req_a[i].q_valid = v.valid[i];
      else req_b[i].q_valid = v.valid[i];
    end
    bank.q_ready = v.ready;
    bank.p_data = 32'hD000_0000 + 32'(n);
    #4;
    if (inst == 0) begin flat = a_rsp; o = a_oup; id = a_idx; end
    else begin flat = b_rsp; o = b_oup; id = b_idx; end
    for (int i = 0; i < 4; i++) begin
      r = flat[i*RspW +: RspW];
      qr[i] = r.q_ready;
      pv[i] = r.p_valid;
      pd[i] = r.p_data;
    end
    $display("%s: valid=%b ready=%b idx=%0d oup_valid=%b q_ready=%b p_valid=%b",
             p, v.valid, v.ready, id, o.q_valid, qr, pv);
    check({p, " idx"}, 64'(id), 64'(v.exp_idx));
    check({p, " oup_valid"}, 64'(o.q_valid), 64'(v.exp_ov));
    check({p, " q_ready"}, 64'(qr), 64'(v.exp_qr));
    check({p, " p_valid"}, 64'(pv), 64'(v.exp_pv));
    if (v.exp_ov) check({p, " addr"}, 64'(o.addr), 64'(32'h1000 + 32'(v.exp_idx) * 16));
    if (v.exp_pv != 4'b0000) begin
      for (int i = 0; i < 4; i++) check($sformatf("%s p_data%0d", p, i), 64'(pd[i]), 64'(bank.p_data));
    end
  endtask

  vec_t va [15];
  vec_t vb [15];
  bit   hs_hist [100];

  initial begin
    rsp_t rc;
    req_t oc;
    req_t oa;
    logic [3:0] qra;
    logic prev_stall;
    logic hs;

    // Round-robin, then lock-in on input 2 with input 1 arriving mid-stall.
    va[0]  = mk(4'b1111, 1, 0, 1, 4'b0001, 4'b0000);
    va[1]  = mk(4'b1111, 1, 1, 1, 4'b0010, 4'b0001);
    va[2]  = mk(4'b1111, 1, 2, 1, 4'b0100, 4'b0010);
    va[3]  = mk(4'b1111, 1, 3, 1, 4'b1000, 4'b0100);
    va[4]  = mk(4'b1111, 1, 0, 1, 4'b0001, 4'b1000);
    va[5]  = mk(4'b0100, 0, 2, 1, 4'b0000, 4'b0001);
    va[6]  = mk(4'b0110, 0, 2, 1, 4'b0000, 4'b0000);
    va[7]  = mk(4'b0110, 0, 2, 1, 4'b0000, 4'b0000);
    va[8]  = mk(4'b0110, 1, 2, 1, 4'b0100, 4'b0000);
    va[9]  = mk(4'b0010, 1, 1, 1, 4'b0010, 4'b0100);
    va[10] = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0010);
    va[11] = mk(4'b1001, 1, 3, 1, 4'b1000, 4'b0000);
    va[12] = mk(4'b1001, 0, 0, 1, 4'b0000, 4'b1000);
    va[13] = mk(4'b1001, 1, 0, 1, 4'b0001, 4'b0000);
    va[14] = mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0001);
    // MaxWait=2, latency 3: lock beats starvation, then starved input 3 beats round-robin.
    vb[0]  = mk(4'b1001, 0, 0, 1, 4'b0000, 4'b0000);
    vb[1]  = mk(4'b1001, 0, 0, 1, 4'b0000, 4'b0000);
    vb[2]  = mk(4'b1001, 1, 0, 1, 4'b0001, 4'b0000);
    vb[3]  = mk(4'b1010, 1, 3, 1, 4'b1000, 4'b0000);
    vb[4]  = mk(4'b1010, 1, 1, 1, 4'b0010, 4'b0000);
    vb[5]  = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0001);
    vb[6]  = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b1000);
    vb[7]  = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0010);
    vb[8]  = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0000);
    vb[9]  = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0000);
    vb[10] = mk(4'b0010, 1, 1, 1, 4'b0010, 4'b0000);
    vb[11] = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0000);
    vb[12] = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0000);
    vb[13] = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0010);
    vb[14] = mk(4'b0000, 1, 0, 0, 4'b0001, 4'b0000);

    for (int i = 0; i < 4; i++) begin
      req_a[i] = '0;
      req_a[i].addr = 32'h1000 + 32'(i) * 16;
      req_a[i].write = (i == 1);
      req_a[i].data = 32'hA0 + 32'(i);
      req_a[i].strb = 4'hF;
      req_b[i] = req_a[i];
      req_a[i].q_valid = 1'b1;
    end
    c_req = '0;
    c_req.addr = 32'h2000;
    c_req.q_valid = 1'b1;
    bank = '0;
    bank.q_ready = 1'b1;

    // Reset state with requests and ready asserted.
    repeat (2) @(posedge clk);
    #5;
    oa = a_oup;
    for (int i = 0; i < 4; i++) begin
      rc = a_rsp[i*RspW +: RspW];
      qra[i] = rc.q_ready | rc.p_valid;
    end
    oc = c_oup;
    $display("RST: a_valid=%b a_ready|pvalid=%b a_addr=%0h c_valid=%b", oa.q_valid, qra, oa.addr, oc.q_valid);
    check("rst a_oup_valid", 64'(oa.q_valid), 64'(0));
    check("rst a_ready_pvalid", 64'(qra), 64'(0));
    check("rst a_addr", 64'(oa.addr), 64'(32'h1000));
    check("rst a_idx", 64'(a_idx), 64'(0));
    check("rst c_oup_valid", 64'(oc.q_valid), 64'(0));
    #1;
    clear_inputs();
    rst_n = 1'b1;

    for (int n = 0; n < 15; n++) run_vec(0, va[n], n);
    pulse_reset();
    for (int n = 0; n < 15; n++) run_vec(1, vb[n], n);
    pulse_reset();

    // Single input: random valid/ready with the hold rule respected.
    prev_stall = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      c_req.q_valid = prev_stall ? 1'b1 : 1'($urandom_range(0, 1));
      bank.q_ready = 1'($urandom_range(0, 1));
      #4;
      rc = c_rsp;
      oc = c_oup;
      hs = c_req.q_valid & bank.q_ready;
      $display("C%0d: valid=%b ready=%b oup_valid=%b q_ready=%b p_valid=%b", n, c_req.q_valid,
               bank.q_ready, oc.q_valid, rc.q_ready, rc.p_valid);
      check($sformatf("C%0d p_valid", n), 64'(rc.p_valid), 64'((n >= 2) ? hs_hist[n-2] : 1'b0));
      check($sformatf("C%0d q_ready", n), 64'(rc.q_ready), 64'(bank.q_ready));
      check($sformatf("C%0d oup_valid", n), 64'(oc.q_valid), 64'(c_req.q_valid));
      check($sformatf("C%0d idx", n), 64'(c_idx), 64'(0));
      hs_hist[n] = hs;
      prev_stall = c_req.q_valid & ~bank.q_ready;
    end

    // Mid-flight reset: handshake at t, reset during t+1, nothing comes back.
    @(posedge clk); #1;
    c_req.q_valid = 1'b1;
    bank.q_ready = 1'b1;
    #4;
    rc = c_rsp;
    $display("MF t: q_ready=%b", rc.q_ready);
    check("mf t q_ready", 64'(rc.q_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #4;
    rc = c_rsp;
    oc = c_oup;
    $display("MF t+1: oup_valid=%b q_ready=%b p_valid=%b", oc.q_valid, rc.q_ready, rc.p_valid);
    check("mf t+1 oup_valid", 64'(oc.q_valid), 64'(0));
    check("mf t+1 q_ready", 64'(rc.q_ready), 64'(0));
    check("mf t+1 p_valid", 64'(rc.p_valid), 64'(0));
    @(posedge clk); #5;
    rc = c_rsp;
    $display("MF t+2: p_valid=%b", rc.p_valid);
    check("mf t+2 p_valid", 64'(rc.p_valid), 64'(0));
    #1;
    clear_inputs();
    bank.q_ready = 1'b1;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #5;
      rc = c_rsp;
      $display("MF post%0d: p_valid=%b", n, rc.p_valid);
      check($sformatf("mf post%0d p_valid", n), 64'(rc.p_valid), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
